// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register encodings, instruction codes, write-back states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

  // Register index meaning "no register"; also the idle value of rf_waddr.
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] REG_RSP = 4'h4;

  // Instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_E = 2'd1,
    WRITE_M = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match of one decode read index against the pending M and E writes.
// Latency: combinational.  Backpressure: none.
// Ports: src (read index); m_pend/dstM/valM and e_pend/dstE/valE (pending
// writes); hit/data (forwarding result, data=0 on miss).
module wb_fwd_match #(
  parameter int              DATA_W = 64,
  parameter int              REG_W  = 4,
  parameter logic [REG_W-1:0] RNONE = y86_pkg::RNONE
) (
  input  logic [REG_W-1:0]  src,
  input  logic              m_pend,
  input  logic [REG_W-1:0]  dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              e_pend,
  input  logic [REG_W-1:0]  dstE,
  input  logic [DATA_W-1:0] valE,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // M is checked first: it is the younger value when both target the same register.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (src != RNONE) begin
      if (m_pend && src == dstM) begin
        hit  = 1'b1;
        data = valM;
      end else if (e_pend && src == dstE) begin
        hit  = 1'b1;
        data = valE;
      end
    end
  end

endmodule

// File: rtl/wb_port_sequencer.sv
// Serialises E/M write-back pairs onto one register-file write port, with forwarding.
// Latency: first write issued the cycle after accept; dual writes take two cycles.
// Backpressure: req_ready high in IDLE or on a request's final write cycle only.
// Ports: req_* (write-back request handshake), rf_* (register-file write port),
// srcA/srcB + fwd*_hit/fwd*_data (decode forwarding), wb_done, wb_count.
module wb_port_sequencer
  import y86_pkg::wb_state_t, y86_pkg::IDLE, y86_pkg::WRITE_E, y86_pkg::WRITE_M;
#(
  parameter int               DATA_W = 64,
  parameter int               REG_W  = 4,
  parameter logic [REG_W-1:0] RNONE  = y86_pkg::RNONE,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_W-1:0]  req_dstE,
  input  logic [DATA_W-1:0] req_valE,
  input  logic [REG_W-1:0]  req_dstM,
  input  logic [DATA_W-1:0] req_valM,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_W-1:0]  srcA,
  input  logic [REG_W-1:0]  srcB,
  output logic              fwdA_hit,
  output logic [DATA_W-1:0] fwdA_data,
  output logic              fwdB_hit,
  output logic [DATA_W-1:0] fwdB_data,
  output logic              wb_done,
  output logic [CNT_W-1:0]  wb_count
);

  wb_state_t         state_q, state_d;
  logic [REG_W-1:0]  dstE_q, dstM_q;
  logic [DATA_W-1:0] valE_q, valM_q;
  logic [CNT_W-1:0]  cnt_q;

  logic      effM, final_wr, accept, req_effM, req_effE;
  wb_state_t first_state;

  // Held request: on a same-register collision the M write wins.
  assign effM = (dstM_q != RNONE);

  // Incoming request decode, used only to pick the first state on accept.
  assign req_effM    = (req_dstM != RNONE);
  assign req_effE    = (req_dstE != RNONE) && !(req_effM && req_dstE == req_dstM);
  assign first_state = req_effE ? WRITE_E : (req_effM ? WRITE_M : IDLE);

  assign final_wr  = (state_q == WRITE_M) || (state_q == WRITE_E && !effM);
  assign req_ready = (state_q == IDLE) || final_wr;
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a final write cycle may take the next request with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? first_state : IDLE;
      WRITE_E: state_d = effM ? WRITE_M : (accept ? first_state : IDLE);
      WRITE_M: state_d = accept ? first_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = RNONE;
    rf_wdata = '0;
    case (state_q)
      WRITE_E: begin
        rf_we    = 1'b1;
        rf_waddr = dstE_q;
        rf_wdata = valE_q;
      end
      WRITE_M: begin
        rf_we    = 1'b1;
        rf_waddr = dstM_q;
        rf_wdata = valM_q;
      end
      default: ;
    endcase
  end

  assign wb_done = final_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstE_q <= RNONE;
      dstM_q <= RNONE;
      valE_q <= '0;
      valM_q <= '0;
    end else if (accept) begin
      dstE_q <= req_dstE;
      dstM_q <= req_dstM;
      valE_q <= req_valE;
      valM_q <= req_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (rf_we) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign wb_count = cnt_q;

  // A write stays pending through the cycle that issues it.
  logic m_pend, e_pend;
  assign m_pend = (state_q == WRITE_E || state_q == WRITE_M) && effM;
  assign e_pend = (state_q == WRITE_E);

  wb_fwd_match #(.DATA_W(DATA_W), .REG_W(REG_W), .RNONE(RNONE)) u_fwd_a (
    .src    (srcA),
    .m_pend (m_pend),
    .dstM   (dstM_q),
    .valM   (valM_q),
    .e_pend (e_pend),
    .dstE   (dstE_q),
    .valE   (valE_q),
    .hit    (fwdA_hit),
    .data   (fwdA_data)
  );

  wb_fwd_match #(.DATA_W(DATA_W), .REG_W(REG_W), .RNONE(RNONE)) u_fwd_b (
    .src    (srcB),
    .m_pend (m_pend),
    .dstM   (dstM_q),
    .valM   (valM_q),
    .e_pend (e_pend),
    .dstE   (dstE_q),
    .valE   (valE_q),
    .hit    (fwdB_hit),
    .data   (fwdB_data)
  );

endmodule

// File: doc/wb_port_sequencer.md
Name: wb_port_sequencer

Overview:
- Serialises SEQ write-back onto a single register-file write port.
- One retired instruction can carry two writes: dstE/valE (ALU result) and dstM/valM (memory result). popq carries both.
- Accepts one write-back request per handshake and issues each write on its own cycle.
- Forwards any still-pending value to the decode read indices so decode never sees stale register contents.

Parameters:
- DATA_W, 64, register data width
- REG_W, 4, register index width
- RNONE, 4'hF, "no register" encoding
- CNT_W, 16, width of the write counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write-back request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_dstE  in  REG_W  E destination; RNONE means no E write
- req_valE  in  DATA_W  E data
- req_dstM  in  REG_W  M destination; RNONE means no M write
- req_valM  in  DATA_W  M data
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_W  write index
- rf_wdata  out  DATA_W  write data
- srcA  in  REG_W  decode read index A
- srcB  in  REG_W  decode read index B
- fwdA_hit  out  1  srcA matches a pending write
- fwdA_data  out  DATA_W  forwarded value for srcA
- fwdB_hit  out  1  srcB matches a pending write
- fwdB_data  out  DATA_W  forwarded value for srcB
- wb_done  out  1  final write of a request is issued this cycle
- wb_count  out  CNT_W  total rf_we cycles, wraps

Behaviour:
- Clocking and reset
  - All flops on posedge clk or negedge rst_n.
  - Reset values: state=IDLE; holding registers dstE=dstM=RNONE, valE=valM=0; wb_count=0.
  - With those reset values, rf_we=0, rf_waddr=RNONE, rf_wdata=0, wb_done=0, fwd hits=0, req_ready=1.
  - Reset mid-operation discards any pending writes; no partial write follows deassertion.
- States: IDLE, WRITE_E, WRITE_M.
- Accept
  - A request is accepted when req_valid && req_ready.
  - On accept, req_dst*/req_val* are latched into the holding registers.
- Effective writes
  - effM = (dstM != RNONE).
  - effE = (dstE != RNONE) && !(effM && dstE == dstM).
  - On a same-register collision the M write wins and E is dropped.
- Next state after accept
  - WRITE_E if effE.
  - Else WRITE_M if effM.
  - Else IDLE: the request is silently consumed, with no write, no wb_done, and no count.
- WRITE_E
  - rf_we=1, rf_waddr=dstE, rf_wdata=valE.
  - Next state: WRITE_M if effM, else final.
- WRITE_M
  - rf_we=1, rf_waddr=dstM, rf_wdata=valM.
  - Always final.
- Final write cycle
  - wb_done=1 and req_ready=1.
  - A request accepted in the same cycle goes directly to its first state (back-to-back, no bubble).
  - Otherwise the next state is IDLE.
- req_ready
  - Equals (state==IDLE) || final write cycle.
  - Does not depend on req_valid, so there is no combinational loop.
- Latency and throughput
  - The first write is issued the cycle after accept.
  - Sustained throughput is one request per cycle for single-write requests, one per two cycles for dual writes.
- rf_we, rf_waddr, rf_wdata and wb_done are decoded from registered state only; they have no combinational path from req_*.
- Forwarding (combinational from srcX and registered state)
  - Only pending writes are considered; the rf write lands at the end of its cycle, so it is still pending during that cycle.
  - If srcX != RNONE and state∈{WRITE_E, WRITE_M} and effM and srcX==dstM: hit, data=valM.
  - Else if srcX != RNONE and state==WRITE_E and srcX==dstE: hit, data=valE.
  - Else: hit=0, data=0.
  - srcX==RNONE never hits.
- wb_count increments by 1 on every cycle with rf_we=1 and wraps from 2^CNT_W−1 to 0.

Decomposition:
- Shared package y86_pkg: RNONE, REG_RSP=4'h4, the icode constants, and wb_state_t (IDLE, WRITE_E, WRITE_M).
- One natural sub-module: wb_fwd_match, a combinational priority match of one src index against pending E/M. Instantiated twice (A and B).

Test Plan:
- Reset/idle: hold rst_n=0, then release.
  - Required: rf_we=0, req_ready=1, wb_count=0, rf_waddr=4'hF.
  - Assert rst_n=0 during WRITE_E: no write follows.
- Single E write: req dstE=3, valE=0x55, dstM=F.
  - Next cycle: rf_we=1, waddr=3, wdata=0x55, wb_done=1, req_ready=1.
  - Following cycle: rf_we=0.
- popq %rbx: dstE=4, valE=0x1008, dstM=3, valM=0xABCD.
  - Cycle 1: write 4←0x1008, req_ready=0.
  - Cycle 2: write 3←0xABCD, wb_done=1.
  - Throughout, srcA=3 gives fwdA_hit=1, data=0xABCD.
  - In cycle 1, srcB=4 gives fwdB_hit=1, data=0x1008.
- Collision, popq %rsp: dstE=4, valE=0x10, dstM=4, valM=0x99.
  - One write only: 4←0x99.
  - wb_count advances by 1.
- Back-to-back: three single-E requests held valid continuously (regs 1, 2, 5).
  - Three consecutive rf_we cycles with no bubble.
  - wb_count=3.
- Null request and wrap:
  - dstE=dstM=F: accepted, with no rf_we and no wb_done.
  - Preload wb_count to 0xFFFF via 65535 writes; one more write gives 0x0000.
